// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Latency BIN_W cycles accept-to-out_valid; throughput one result per BIN_W+2 cycles; holds result until out_ready.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  ovf,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W);
    localparam bit SGN = (SIGNED != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [BW-1:0]    r_bcd_sh;
    logic [BIN_W-1:0] r_bin_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf_acc;
    logic             r_sign_acc;
    logic [BW-1:0]    r_bcd;
    logic             r_sign;
    logic             r_ovf;

    logic [BW-1:0]    w_adj;
    logic [BW-1:0]    w_next_bcd;
    logic [BIN_W-1:0] w_next_bin;
    logic [BIN_W-1:0] w_mag;
    logic             w_neg;
    logic             w_ovf_next;
    logic             w_last;

    always_comb begin
        w_adj = r_bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd_sh[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd_sh[4*i +: 4] + 4'd3;
        end
    end

    // Whole {bcd, binary} register shifts left; bit leaving the BCD MSB means the value did not fit.
    assign w_next_bcd = {w_adj[BW-2:0], r_bin_sh[BIN_W-1]};
    assign w_next_bin = {r_bin_sh[BIN_W-2:0], 1'b0};
    assign w_ovf_next = r_ovf_acc | w_adj[BW-1];
    assign w_last     = (r_cnt == CW'(BIN_W - 1));

    assign w_neg = SGN & bin[BIN_W-1];
    assign w_mag = w_neg ? (~bin + 1'b1) : bin;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bcd_sh   <= '0;
            r_bin_sh   <= '0;
            r_cnt      <= '0;
            r_ovf_acc  <= 1'b0;
            r_sign_acc <= 1'b0;
            r_bcd      <= '0;
            r_sign     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_bin_sh   <= w_mag;
                        r_bcd_sh   <= '0;
                        r_cnt      <= '0;
                        r_ovf_acc  <= 1'b0;
                        r_sign_acc <= w_neg;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd_sh  <= w_next_bcd;
                    r_bin_sh  <= w_next_bin;
                    r_ovf_acc <= w_ovf_next;
                    r_cnt     <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Output registers update only here so they stay put across later conversions.
                        r_bcd   <= w_next_bcd;
                        r_ovf   <= w_ovf_next;
                        r_sign  <= r_sign_acc;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_CONV);
    assign out_valid = (r_state == S_DONE);
    assign bcd       = r_bcd;
    assign sign      = r_sign;
    assign ovf       = r_ovf;

endmodule
